// File: rtl/mem_pkg.sv
// Shared types and constants for the mem_dual_clr RAM and its clear engine.
// Build option: MEM_DUAL_CLR_PARITY_EN (see mem_dual_clr.sv).
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

package mem_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  localparam int unsigned READ_LATENCY_MIN = 1;
  localparam int unsigned READ_LATENCY_MAX = 2;

  function automatic bit read_latency_ok(int unsigned lat);
    return (lat >= READ_LATENCY_MIN) && (lat <= READ_LATENCY_MAX);
  endfunction

endpackage

// File: rtl/mem_clear_fsm.sv
// Clear engine: walks addresses 0..DEPTH-1, one word per cycle, while busy_o is high.
// A reset in the middle of a sweep stops it before that cycle's write.
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

module mem_clear_fsm
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = `CLOG2(DEPTH)
) (
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic          clear_i,
  output logic          busy_o,
  output logic          we_o,
  output logic [AW-1:0] addr_o
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  clr_state_e    state_q;
  logic [AW-1:0] count_q;
  logic          busy_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (clear_i) begin
            state_q <= ST_CLEAR;
            count_q <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          // Terminal compare against DEPTH-1 so non-power-of-two depths never wrap.
          if (count_q == LAST_ADDR) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            busy_q  <= 1'b0;
          end else begin
            count_q <= count_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign we_o   = busy_q & ~reset_i;
  assign addr_o = count_q;

endmodule

// File: rtl/mem_dual_clr.sv
// True dual-port RAM with 1/2-cycle read latency, collision policy, range guard and clear engine.
// Build option: MEM_DUAL_CLR_PARITY_EN adds a stored even-parity bit and parity_err_0/1 outputs.
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

module mem_dual_clr
  import mem_pkg::*;
#(
  parameter int unsigned      WIDTH        = 8,
  parameter int unsigned      DEPTH        = 64,
  parameter int unsigned      READ_LATENCY = 1,
  parameter logic [WIDTH-1:0] CLEAR_VALUE  = '0,
  // Preload file name, consumed by the target's memory-initialisation flow.
  parameter string            FILE         = ""
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      clear,
  output logic                      busy,
  input  logic [WIDTH-1:0]          data_0,
  input  logic [`CLOG2(DEPTH)-1:0]  address_0,
  input  logic                      wren_0,
  output logic [WIDTH-1:0]          q_0,
  input  logic [WIDTH-1:0]          data_1,
  input  logic [`CLOG2(DEPTH)-1:0]  address_1,
  input  logic                      wren_1,
  output logic [WIDTH-1:0]          q_1
`ifdef MEM_DUAL_CLR_PARITY_EN
  ,
  output logic                      parity_err_0,
  output logic                      parity_err_1
`endif
);

  localparam int unsigned AW = `CLOG2(DEPTH);
`ifdef MEM_DUAL_CLR_PARITY_EN
  localparam int unsigned MW = WIDTH + 1;
`else
  localparam int unsigned MW = WIDTH;
`endif
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  if (!read_latency_ok(READ_LATENCY)) begin : g_bad_latency
    $error("mem_dual_clr: READ_LATENCY must be 1 or 2");
  end

  function automatic logic [MW-1:0] encode(input logic [WIDTH-1:0] d);
`ifdef MEM_DUAL_CLR_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  logic [MW-1:0]    mem [DEPTH];
  logic [MW-1:0]    rd_word_0, rd_word_1;
  logic             in_range_0, in_range_1;
  logic             eng_we;
  logic [AW-1:0]    eng_addr;
  logic             we_a, we_b;
  logic [AW-1:0]    addr_a;
  logic [WIDTH-1:0] wdata_a;

  mem_clear_fsm #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clear_fsm (
    .clock_i (clock),
    .reset_i (reset),
    .clear_i (clear),
    .busy_o  (busy),
    .we_o    (eng_we),
    .addr_o  (eng_addr)
  );

  assign in_range_0 = {1'b0, address_0} < DEPTH_W;
  assign in_range_1 = {1'b0, address_1} < DEPTH_W;

  // Port A carries the clear engine while busy; user writes are locked out then.
  assign we_a    = eng_we | (wren_0 & ~busy & in_range_0);
  assign addr_a  = eng_we ? eng_addr : address_0;
  assign wdata_a = eng_we ? CLEAR_VALUE : data_0;
  // Same-address collision: port 0 wins, port 1's write is dropped.
  assign we_b    = wren_1 & ~busy & in_range_1 &
                   ~(wren_0 & in_range_0 & (address_0 == address_1));

  // NOTE: the array has no reset branch on purpose; contents survive reset and
  // a reset-free memory maps onto block RAM.
  always_ff @(posedge clock) begin
    if (we_a) mem[addr_a] <= encode(wdata_a);
    if (we_b) mem[address_1] <= encode(data_1);
  end

  assign rd_word_0 = mem[address_0];
  assign rd_word_1 = mem[address_1];

  logic [WIDTH-1:0] q0_s1_d, q0_s1_q, q1_s1_d, q1_s1_q;

  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    q0_s1_d = '0;
    q1_s1_d = '0;
    if (!busy && in_range_0) q0_s1_d = wren_0 ? data_0 : rd_word_0[WIDTH-1:0];
    if (in_range_1) q1_s1_d = (wren_1 && !busy) ? data_1 : rd_word_1[WIDTH-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      q0_s1_q <= '0;
      q1_s1_q <= '0;
    end else begin
      q0_s1_q <= q0_s1_d;
      q1_s1_q <= q1_s1_d;
    end
  end

`ifdef MEM_DUAL_CLR_PARITY_EN
  logic pe0_s1_d, pe0_s1_q, pe1_s1_d, pe1_s1_q;

  assign pe0_s1_d = !busy && in_range_0 && !wren_0 &&
                    (rd_word_0[WIDTH] != ^rd_word_0[WIDTH-1:0]);
  assign pe1_s1_d = in_range_1 && !(wren_1 && !busy) &&
                    (rd_word_1[WIDTH] != ^rd_word_1[WIDTH-1:0]);

  always_ff @(posedge clock) begin
    if (reset) begin
      pe0_s1_q <= 1'b0;
      pe1_s1_q <= 1'b0;
    end else begin
      pe0_s1_q <= pe0_s1_d;
      pe1_s1_q <= pe1_s1_d;
    end
  end
`endif

  if (READ_LATENCY == 2) begin : g_lat2
    logic [WIDTH-1:0] q0_s2_q, q1_s2_q;

    always_ff @(posedge clock) begin
      if (reset) begin
        q0_s2_q <= '0;
        q1_s2_q <= '0;
      end else begin
        q0_s2_q <= q0_s1_q;
        q1_s2_q <= q1_s1_q;
      end
    end

    assign q_0 = q0_s2_q;
    assign q_1 = q1_s2_q;

`ifdef MEM_DUAL_CLR_PARITY_EN
    logic pe0_s2_q, pe1_s2_q;

    always_ff @(posedge clock) begin
      if (reset) begin
        pe0_s2_q <= 1'b0;
        pe1_s2_q <= 1'b0;
      end else begin
        pe0_s2_q <= pe0_s1_q;
        pe1_s2_q <= pe1_s1_q;
      end
    end

    assign parity_err_0 = pe0_s2_q;
    assign parity_err_1 = pe1_s2_q;
`endif
  end else begin : g_lat1
    assign q_0 = q0_s1_q;
    assign q_1 = q1_s1_q;
`ifdef MEM_DUAL_CLR_PARITY_EN
    assign parity_err_0 = pe0_s1_q;
    assign parity_err_1 = pe1_s1_q;
`endif
  end

endmodule

// File: tb/tb_mem_dual_clr.sv
// Scoreboard bench for mem_dual_clr: three instances (latency 1, latency 2 with fill value,
// DEPTH=48) share one stimulus stream; expectations are queued and checked by a monitor.
module tb_mem_dual_clr;

  localparam int SEL_QA0 = 0, SEL_QA1 = 1, SEL_QB0 = 2, SEL_QB1 = 3, SEL_QC0 = 4, SEL_QC1 = 5;
  localparam int SEL_BA = 6, SEL_BB = 7, SEL_BC = 8, SEL_PA1 = 9;
  localparam logic [7:0] FILL_B = 8'h5A;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, clear, w0, w1;
  logic [7:0] d0, d1;
  logic [5:0] a0, a1;
  logic       busy_a, busy_b, busy_c;
  logic [7:0] qa0, qa1, qb0, qb1, qc0, qc1;
`ifdef MEM_DUAL_CLR_PARITY_EN
  logic pa0, pa1, pb0, pb1, pc0, pc1;
`endif

  mem_dual_clr #(.WIDTH(8), .DEPTH(64), .READ_LATENCY(1)) dut_a (
    .clock(clk), .reset(reset), .clear(clear), .busy(busy_a),
    .data_0(d0), .address_0(a0), .wren_0(w0), .q_0(qa0),
    .data_1(d1), .address_1(a1), .wren_1(w1), .q_1(qa1)
`ifdef MEM_DUAL_CLR_PARITY_EN
    , .parity_err_0(pa0), .parity_err_1(pa1)
`endif
  );

  mem_dual_clr #(.WIDTH(8), .DEPTH(64), .READ_LATENCY(2), .CLEAR_VALUE(FILL_B)) dut_b (
    .clock(clk), .reset(reset), .clear(clear), .busy(busy_b),
    .data_0(d0), .address_0(a0), .wren_0(w0), .q_0(qb0),
    .data_1(d1), .address_1(a1), .wren_1(w1), .q_1(qb1)
`ifdef MEM_DUAL_CLR_PARITY_EN
    , .parity_err_0(pb0), .parity_err_1(pb1)
`endif
  );

  mem_dual_clr #(.WIDTH(8), .DEPTH(48), .READ_LATENCY(1)) dut_c (
    .clock(clk), .reset(reset), .clear(clear), .busy(busy_c),
    .data_0(d0), .address_0(a0), .wren_0(w0), .q_0(qc0),
    .data_1(d1), .address_1(a1), .wren_1(w1), .q_1(qc1)
`ifdef MEM_DUAL_CLR_PARITY_EN
    , .parity_err_0(pc0), .parity_err_1(pc1)
`endif
  );

  typedef struct {
    int         due;
    int         sel;
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] observe(input int sel);
    case (sel)
      SEL_QA0: return qa0;
      SEL_QA1: return qa1;
      SEL_QB0: return qb0;
      SEL_QB1: return qb1;
      SEL_QC0: return qc0;
      SEL_QC1: return qc1;
      SEL_BA:  return {7'd0, busy_a};
      SEL_BB:  return {7'd0, busy_b};
      SEL_BC:  return {7'd0, busy_c};
`ifdef MEM_DUAL_CLR_PARITY_EN
      SEL_PA1: return {7'd0, pa1};
`endif
      default: return 8'hxx;
    endcase
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares every queued expectation that falls due on this cycle.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        check(sb[i].name, observe(sb[i].sel), sb[i].exp);
        sb.delete(i);
      end else if (sb[i].due < cyc) begin
        check({sb[i].name, "_missed"}, 8'hxx, sb[i].exp);
        sb.delete(i);
      end
    end
  end

  task automatic exp_push(input int sel, input logic [7:0] v, input int lat, input string name);
    sb.push_back('{cyc + lat, sel, v, name});
  endtask

  // Queue one read/write-through result on port p for all three instances.
  task automatic exp_q(input int p, input logic [7:0] va, input logic [7:0] vb,
                       input logic [7:0] vc, input string name);
    exp_push(SEL_QA0 + p, va, 1, {name, "_a"});
    exp_push(SEL_QB0 + p, vb, 2, {name, "_b"});
    exp_push(SEL_QC0 + p, vc, 1, {name, "_c"});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [7:0] base);
    for (int i = 0; i < 64; i++) begin
      w0 = 1'b1; a0 = 6'(i); d0 = base + 8'(i);
      tick();
    end
    w0 = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; w0 = 1'b0; w1 = 1'b0;
    d0 = '0; d1 = '0; a0 = '0; a1 = '0;
    tick(); tick();
    for (int s = SEL_QA0; s <= SEL_BC; s++) exp_push(s, 8'h00, 0, "reset_state");
    reset = 1'b0;
    tick();

    // Write 0xA5 @3 with write-through, then read it back on port 1.
    w0 = 1'b1; a0 = 6'd3; d0 = 8'hA5;
    exp_q(0, 8'hA5, 8'hA5, 8'hA5, "wt0_a5");
    tick();
    w0 = 1'b0; a1 = 6'd3;
    exp_q(1, 8'hA5, 8'hA5, 8'hA5, "rd1_a5");
    tick();

    // Mixed-port read during write returns old data.
    w0 = 1'b1; a0 = 6'd3; d0 = 8'h3C; a1 = 6'd3;
    exp_q(1, 8'hA5, 8'hA5, 8'hA5, "rdw_old");
    tick();
    w0 = 1'b0;
    exp_q(1, 8'h3C, 8'h3C, 8'h3C, "rdw_new");
    tick();

    // Same-address collision: port 0 data is stored.
    w0 = 1'b1; a0 = 6'd5; d0 = 8'h11;
    w1 = 1'b1; a1 = 6'd5; d1 = 8'h22;
    exp_q(0, 8'h11, 8'h11, 8'h11, "col_q0");
    exp_q(1, 8'h22, 8'h22, 8'h22, "col_q1");
    tick();
    w0 = 1'b0; w1 = 1'b0;
    exp_q(0, 8'h11, 8'h11, 8'h11, "col_rd0");
    exp_q(1, 8'h11, 8'h11, 8'h11, "col_rd1");
    tick();

    // Address 50: in range for DEPTH=64, out of range for DEPTH=48.
    w0 = 1'b1; a0 = 6'd50; d0 = 8'h77;
    exp_push(SEL_QA0, 8'h77, 1, "wt_50_a");
    exp_push(SEL_QB0, 8'h77, 2, "wt_50_b");
    tick();
    w0 = 1'b0; a1 = 6'd50;
    exp_q(1, 8'h77, 8'h77, 8'h00, "rd_50");
    tick();

    // Fill, then run a full clear with writes and a clear pulse during busy.
    fill(8'h40);
    a1 = 6'd20;
    exp_q(1, 8'h54, 8'h54, 8'h54, "fill_rd20");
    tick();
    clear = 1'b1; w0 = 1'b1; a0 = 6'd0; d0 = 8'hFF;
    for (int k = 0; k < 66; k++) begin
      exp_push(SEL_BA, {7'd0, k < 64}, 1 + k, $sformatf("busy_a_k%0d", k));
      exp_push(SEL_BB, {7'd0, k < 64}, 1 + k, $sformatf("busy_b_k%0d", k));
      exp_push(SEL_BC, {7'd0, k < 48}, 1 + k, $sformatf("busy_c_k%0d", k));
    end
    tick();
    clear = 1'b0; w0 = 1'b0;
    for (int k = 0; k < 70; k++) begin
      case (k)
        2: begin
          a1 = 6'd63;
          exp_q(1, 8'h7F, 8'h7F, 8'h00, "busy_rd63_old");
        end
        3: begin
          w0 = 1'b1; a0 = 6'd1; d0 = 8'h99;
          w1 = 1'b1; a1 = 6'd2; d1 = 8'h99;
          exp_q(0, 8'h00, 8'h00, 8'h00, "busy_q0_zero");
        end
        4: begin
          w0 = 1'b0; w1 = 1'b0;
        end
        5: begin
          a1 = 6'd1;
          exp_q(1, 8'h00, FILL_B, 8'h00, "busy_rd1_cleared");
        end
        10: clear = 1'b1;
        11: clear = 1'b0;
        default: ;
      endcase
      tick();
    end
    for (int i = 0; i < 64; i++) begin
      a0 = 6'(i); a1 = 6'(i);
      exp_q(0, 8'h00, FILL_B, 8'h00, $sformatf("clr_rd0_%0d", i));
      exp_q(1, 8'h00, FILL_B, 8'h00, $sformatf("clr_rd1_%0d", i));
      tick();
    end

    // Reset during clear cycle 10 aborts the sweep after words 0..9.
    fill(8'h80);
    clear = 1'b1;
    exp_push(SEL_BA, 8'h01, 1, "abort_busy_start_a");
    exp_push(SEL_BC, 8'h01, 1, "abort_busy_start_c");
    tick();
    clear = 1'b0;
    repeat (10) tick();
    exp_push(SEL_BB, 8'h01, 0, "abort_busy_pre_b");
    reset = 1'b1;
    exp_push(SEL_BA, 8'h00, 1, "abort_busy_a");
    exp_push(SEL_BB, 8'h00, 1, "abort_busy_b");
    exp_push(SEL_BC, 8'h00, 1, "abort_busy_c");
    tick();
    reset = 1'b0;
    for (int i = 0; i < 64; i++) begin
      logic [7:0] old_v;
      old_v = 8'h80 + 8'(i);
      a1 = 6'(i);
      exp_q(1, (i < 10) ? 8'h00 : old_v, (i < 10) ? FILL_B : old_v,
            (i < 10 || i >= 48) ? 8'h00 : old_v, $sformatf("abort_rd_%0d", i));
      tick();
    end

`ifdef MEM_DUAL_CLR_PARITY_EN
    // Corrupt one stored data bit of word 7 and read it next to a clean word 8.
    w0 = 1'b1; a0 = 6'd7; d0 = 8'h0F;
    tick();
    a0 = 6'd8;
    tick();
    w0 = 1'b0;
    dut_a.mem[7] = dut_a.mem[7] ^ 9'h001;
    a1 = 6'd7;
    exp_push(SEL_QA1, 8'h0E, 1, "par_q_7");
    exp_push(SEL_PA1, 8'h01, 1, "par_err_7");
    tick();
    a1 = 6'd8;
    exp_push(SEL_QA1, 8'h0F, 1, "par_q_8");
    exp_push(SEL_PA1, 8'h00, 1, "par_err_8");
    tick();
`endif

    repeat (5) tick();
    while (sb.size() != 0) begin
      check({sb[0].name, "_never_checked"}, 8'hxx, sb[0].exp);
      void'(sb.pop_front());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
